// File: rtl/adder_accum_ctrl_pkg.sv
// Shared types and elaboration helpers for the multi-beat adder accumulator.
package adder_accum_ctrl_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Beat counter width; a single-beat transaction still needs a 1-bit register.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic bit params_legal(input int width, input int beats, input int sum_width);
    return (beats >= 1) && (sum_width >= width + 1);
  endfunction

endpackage

// File: rtl/adder_accum_ctrl_add3.sv
// Three-operand adder; the extra output bit holds the carry out of the top bit.
module adder_accum_ctrl_add3 #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic [width_p-1:0] c_i,
  output logic [width_p:0]   sum_o
);

  // One carry bit is enough only when the callers keep b_i + c_i below 2^width_p.
  assign sum_o = {1'b0, a_i} + {1'b0, b_i} + {1'b0, c_i};

endmodule

// File: rtl/adder_accum_ctrl.sv
// Sequences a shared 3-input adder over beats_p operand beats, then holds the
// total on a valid/ready output until the consumer takes it.
//
//   state | meaning
//   ACCUM | accepting operand beats, acc holds the partial sum
//   DONE  | presenting acc/ovf as the result, waiting for ready_i
module adder_accum_ctrl
  import adder_accum_ctrl_pkg::*;
#(
  parameter int width_p     = 4,
  parameter int beats_p     = 4,
  parameter int sum_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [sum_width_p-1:0] sum_o,
  output logic                   overflow_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int cnt_w_lp = cnt_width(beats_p);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(beats_p - 1);

  if (!params_legal(width_p, beats_p, sum_width_p)) begin : g_bad_params
    $error("adder_accum_ctrl: need beats_p >= 1 and sum_width_p >= width_p + 1");
  end

  state_e                 state_q, state_n;
  logic [sum_width_p-1:0] acc_q;
  logic [cnt_w_lp-1:0]    cnt_q;
  logic                   ovf_q;
  logic [sum_width_p:0]   add_sum;
  logic [sum_width_p-1:0] a_ext, b_ext;
  logic                   accept, last_beat, take_result;

  assign a_ext = {{(sum_width_p - width_p){1'b0}}, a_i};
  assign b_ext = {{(sum_width_p - width_p){1'b0}}, b_i};

  adder_accum_ctrl_add3 #(
    .width_p (sum_width_p)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (a_ext),
    .c_i   (b_ext),
    .sum_o (add_sum)
  );

  assign accept      = valid_i & ready_o;
  assign take_result = valid_o & ready_i;
  assign last_beat   = (cnt_q == last_cnt_lp);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ACCUM: if (accept && last_beat) state_n = DONE;
      DONE:  if (take_result)         state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // Handshake outputs are gated by reset so neither side sees a stale state.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    if (!reset_i) begin
      case (state_q)
        ACCUM:   ready_o = 1'b1;
        DONE:    valid_o = 1'b1;
        default: ready_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= add_sum[sum_width_p-1:0];
      ovf_q <= ovf_q | add_sum[sum_width_p];
      cnt_q <= last_beat ? '0 : cnt_q + cnt_w_lp'(1);
    end else if (take_result) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  assign sum_o      = acc_q;
  assign overflow_o = ovf_q;

`ifdef FORMAL
  always @(posedge clk_i) begin
    assert (!(ready_o && valid_o));
    if (!reset_i && !$past(reset_i) && $past(valid_o && !ready_i))
      assert (sum_o == $past(sum_o));
  end
`endif

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Bench for adder_accum_ctrl: directed vector table, hand sequences for the
// narrow-result and single-beat variants, and a random run against a sum model.
module tb_adder_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst, vld, rdy;
  logic [3:0] a, b;

  logic       rdy_d, vld_d, ovf_d;
  logic [7:0] sum_d;
  logic       rdy_w, vld_w, ovf_w;
  logic [5:0] sum_w;
  logic       rdy_1, vld_1, ovf_1;
  logic [7:0] sum_1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_accum_ctrl u_dut (
    .clk_i(clk), .reset_i(rst), .a_i(a), .b_i(b), .valid_i(vld), .ready_o(rdy_d),
    .sum_o(sum_d), .overflow_o(ovf_d), .valid_o(vld_d), .ready_i(rdy)
  );

  adder_accum_ctrl #(.sum_width_p(6)) u_w6 (
    .clk_i(clk), .reset_i(rst), .a_i(a), .b_i(b), .valid_i(vld), .ready_o(rdy_w),
    .sum_o(sum_w), .overflow_o(ovf_w), .valid_o(vld_w), .ready_i(rdy)
  );

  adder_accum_ctrl #(.beats_p(1)) u_b1 (
    .clk_i(clk), .reset_i(rst), .a_i(a), .b_i(b), .valid_i(vld), .ready_o(rdy_1),
    .sum_o(sum_1), .overflow_o(ovf_1), .valid_o(vld_1), .ready_i(rdy)
  );

  typedef struct {
    logic       rst, vld;
    logic [3:0] a, b;
    logic       rdy;
    logic       e_rdy, e_vld;
    logic [7:0] e_sum;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic r, input logic vv, input int aa, input int bb,
                            input logic rr, input logic er, input logic ev,
                            input int es, input logic eo);
    vec_t t;
    t.rst = r; t.vld = vv; t.a = 4'(aa); t.b = 4'(bb); t.rdy = rr;
    t.e_rdy = er; t.e_vld = ev; t.e_sum = 8'(es); t.e_ovf = eo;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic vv, input logic [3:0] aa,
                      input logic [3:0] bb, input logic rr);
    @(posedge clk);
    #1;
    rst = r; vld = vv; a = aa; b = bb; rdy = rr;
    @(negedge clk);
  endtask

  function automatic logic [7:0] sum_of(input int k);
    case (k)
      0:       return sum_d;
      1:       return {2'b00, sum_w};
      default: return sum_1;
    endcase
  endfunction

  function automatic logic rdy_of(input int k);
    return (k == 0) ? rdy_d : (k == 1) ? rdy_w : rdy_1;
  endfunction

  function automatic logic vld_of(input int k);
    return (k == 0) ? vld_d : (k == 1) ? vld_w : vld_1;
  endfunction

  function automatic logic ovf_of(input int k);
    return (k == 0) ? ovf_d : (k == 1) ? ovf_w : ovf_1;
  endfunction

  // Reference: a transaction is the plain integer sum of its beats; the result
  // is that total modulo 2^sum_width, and overflow means the total reached 2^sum_width.
  int m_beats[3] = '{4, 4, 1};
  int m_sw[3]    = '{8, 6, 8};
  int m_total[3];
  int m_n[3];
  bit m_pres[3];

  initial begin
    rst = 1'b1; vld = 1'b0; rdy = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);

    // rst vld  a  b rdy | rdy vld sum ovf
    v(1, 0,  0, 0, 0,   0, 0,   0, 0);
    v(0, 1,  1, 2, 0,   1, 0,   0, 0);
    v(0, 1,  3, 4, 0,   1, 0,   3, 0);
    v(0, 1,  5, 6, 0,   1, 0,  10, 0);
    v(0, 1,  7, 8, 0,   1, 0,  21, 0);
    v(0, 0,  0, 0, 0,   0, 1,  36, 0);
    v(0, 0,  0, 0, 0,   0, 1,  36, 0);
    v(0, 1,  9, 9, 0,   0, 1,  36, 0);
    v(0, 0,  0, 0, 1,   0, 1,  36, 0);
    v(0, 0,  0, 0, 0,   1, 0,   0, 0);
    v(0, 1, 15,15, 0,   1, 0,   0, 0);
    v(0, 1, 15,15, 0,   1, 0,  30, 0);
    v(0, 1, 15,15, 0,   1, 0,  60, 0);
    v(0, 1, 15,15, 0,   1, 0,  90, 0);
    v(0, 0,  0, 0, 1,   0, 1, 120, 0);
    v(0, 1,  1, 1, 0,   1, 0,   0, 0);
    v(0, 0,  9, 9, 0,   1, 0,   2, 0);
    v(0, 0,  9, 9, 0,   1, 0,   2, 0);
    v(0, 1,  2, 2, 0,   1, 0,   2, 0);
    v(0, 0,  9, 9, 0,   1, 0,   6, 0);
    v(0, 1,  3, 3, 0,   1, 0,   6, 0);
    v(0, 1,  4, 4, 0,   1, 0,  12, 0);
    v(0, 0,  0, 0, 0,   0, 1,  20, 0);
    v(0, 0,  0, 0, 1,   0, 1,  20, 0);
    v(0, 1, 15,15, 0,   1, 0,   0, 0);
    v(0, 1, 15,15, 0,   1, 0,  30, 0);
    v(1, 1, 15,15, 0,   0, 0,  60, 0);
    v(0, 1,  1, 0, 1,   1, 0,   0, 0);
    v(0, 1,  1, 0, 1,   1, 0,   1, 0);
    v(0, 1,  1, 0, 1,   1, 0,   2, 0);
    v(0, 1,  1, 0, 1,   1, 0,   3, 0);
    v(0, 0,  0, 0, 1,   0, 1,   4, 0);
    v(0, 0,  0, 0, 0,   1, 0,   0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].rdy);
      chk($sformatf("tbl%0d.ready", i), 32'(rdy_d), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.valid", i), 32'(vld_d), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.sum", i),   32'(sum_d), 32'(tbl[i].e_sum));
      chk($sformatf("tbl%0d.ovf", i),   32'(ovf_d), 32'(tbl[i].e_ovf));
    end

    // Narrow result: four (15,15) beats wrap a 6-bit accumulator once.
    step(1, 0, 0, 0, 0);
    step(0, 1, 15, 15, 0); chk("w6.sum0", 32'(sum_w), 0);
    step(0, 1, 15, 15, 0); chk("w6.sum1", 32'(sum_w), 30);
    step(0, 1, 15, 15, 0); chk("w6.sum2", 32'(sum_w), 60);
    step(0, 1, 15, 15, 0); chk("w6.sum3", 32'(sum_w), 26);
    step(0, 0, 0, 0, 0);
    chk("w6.valid", 32'(vld_w), 1); chk("w6.sum", 32'(sum_w), 56); chk("w6.ovf", 32'(ovf_w), 1);
    step(0, 0, 0, 0, 1);
    chk("w6.hold_sum", 32'(sum_w), 56); chk("w6.hold_ovf", 32'(ovf_w), 1);
    step(0, 0, 0, 0, 0);
    chk("w6.clr_valid", 32'(vld_w), 0); chk("w6.clr_ready", 32'(rdy_w), 1);
    chk("w6.clr_sum", 32'(sum_w), 0);   chk("w6.clr_ovf", 32'(ovf_w), 0);

    // Single beat: a beat held through DONE waits for the handshake.
    step(1, 0, 0, 0, 0);
    step(0, 1, 9, 6, 0);
    chk("b1.ready0", 32'(rdy_1), 1); chk("b1.valid0", 32'(vld_1), 0);
    step(0, 1, 2, 3, 0);
    chk("b1.ready1", 32'(rdy_1), 0); chk("b1.valid1", 32'(vld_1), 1); chk("b1.sum1", 32'(sum_1), 15);
    step(0, 1, 2, 3, 1);
    chk("b1.valid2", 32'(vld_1), 1); chk("b1.sum2", 32'(sum_1), 15);
    step(0, 1, 2, 3, 0);
    chk("b1.ready3", 32'(rdy_1), 1); chk("b1.valid3", 32'(vld_1), 0); chk("b1.sum3", 32'(sum_1), 0);
    step(0, 0, 0, 0, 0);
    chk("b1.valid4", 32'(vld_1), 1); chk("b1.sum4", 32'(sum_1), 5); chk("b1.ovf4", 32'(ovf_1), 0);

    // Random traffic on all three variants against the sum model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic r;
      r = (cyc == 0) || ($urandom_range(0, 49) == 0);
      step(r, ($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom), ($urandom_range(0, 1) == 1));
      for (int k = 0; k < 3; k++) begin
        int mod;
        mod = 1 << m_sw[k];
        chk($sformatf("rnd%0d.k%0d.ready", cyc, k), 32'(rdy_of(k)), 32'(!r && !m_pres[k]));
        chk($sformatf("rnd%0d.k%0d.valid", cyc, k), 32'(vld_of(k)), 32'(!r && m_pres[k]));
        if (cyc > 0)
          chk($sformatf("rnd%0d.k%0d.sum", cyc, k), 32'(sum_of(k)), 32'(m_total[k] % mod));
        if (!r && m_pres[k])
          chk($sformatf("rnd%0d.k%0d.ovf", cyc, k), 32'(ovf_of(k)), 32'(m_total[k] >= mod));
        if (r) begin
          m_total[k] = 0; m_n[k] = 0; m_pres[k] = 0;
        end else if (!m_pres[k] && vld) begin
          m_total[k] += int'(a) + int'(b);
          m_n[k]++;
          if (m_n[k] == m_beats[k]) begin
            m_n[k] = 0;
            m_pres[k] = 1;
          end
        end else if (m_pres[k] && rdy) begin
          m_total[k] = 0;
          m_pres[k] = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
- Sequencer that drives one shared 3-input adder as a multi-beat accumulator.
- Each accepted input beat carries two operands; the adder sums accumulator + a_i + b_i.
- After beats_p beats, the block presents the total on a valid/ready output and then clears for the next transaction.
- Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.

Parameters:
width_p, 4, operand width of a_i/b_i
beats_p, 4, input beats per transaction; must be >= 1
sum_width_p, 8, accumulator/result width; must be >= width_p+1

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
a_i  input  width_p  operand A of current beat
b_i  input  width_p  operand B of current beat
valid_i  input  1  producer has a beat on a_i/b_i
ready_o  output  1  block can accept a beat this cycle
sum_o  output  sum_width_p  accumulated sum; meaningful when valid_o=1
overflow_o  output  1  sticky: some add in this transaction wrapped
valid_o  output  1  result available
ready_i  input  1  consumer takes result this cycle

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- State register: ACCUM, DONE. Datapath registers: acc[sum_width_p], cnt[$clog2(beats_p) or 1 bit if beats_p=1], ovf.
- Reset (reset_i high at a clock edge):
  - state<=ACCUM, acc<=0, cnt<=0, ovf<=0.
  - While reset_i is high, ready_o=0 and valid_o=0 (combinationally gated).
  - After reset: sum_o=0, overflow_o=0, valid_o=0, ready_o=1.
- Reset mid-transaction discards the partial sum and beat count; no result is emitted.
- ACCUM:
  - ready_o=1, valid_o=0.
  - Beat accepted when valid_i & ready_o. On accept:
    - acc<=low sum_width_p bits of acc + zext(a_i) + zext(b_i).
    - ovf<=ovf | carry bit.
    - cnt<=cnt+1.
  - If cnt==beats_p-1 on accept: state<=DONE, cnt<=0.
  - Cycles with valid_i=0 change nothing (bubbles are not counted).
- DONE:
  - ready_o=0, valid_o=1; sum_o=acc and overflow_o=ovf, held stable until handshake.
  - On valid_o & ready_i: acc<=0, ovf<=0, state<=ACCUM.
  - A new beat is accepted no earlier than the cycle after the handshake; input and output never overlap.
- Latency:
  - Last beat accepted at edge t → valid_o=1 from cycle t+1.
  - Minimum transaction period is beats_p+1 cycles.
- Outputs are registered state/acc except the reset gating; no combinational path from valid_i or ready_i to any output.
- Arithmetic:
  - The adder instance runs at width sum_width_p with output sum_width_p+1.
  - Because sum_width_p >= width_p+1, acc + a + b < 2^(sum_width_p+1), so the output MSB is the exact carry.
  - Result wraps modulo 2^sum_width_p; overflow_o records any wrap.
- sum_o outside DONE shows the partial acc (observable, not valid).
- Simultaneous events: ready_i in ACCUM is ignored; valid_i in DONE is ignored (producer must hold its beat).
- beats_p=1: every accepted beat goes straight to DONE.

Decomposition:
- Shared package:
  - state enum {ACCUM, DONE}.
  - Parameter legality checks: beats_p>=1, sum_width_p>=width_p+1. Flag violations with an elaboration-time assert.
- One sub-module:
  - Instantiate the team's 3-input adder module (the adder) at width sum_width_p.
  - Inputs: acc, zero-extended a_i, zero-extended b_i.
  - Sub-module sum MSB → carry; low bits → next acc.
- The controller contains only the FSM, counter, and registers.
- Formal (`ifdef FORMAL):
  - ready_o & valid_o never both 1.
  - sum_o stable while valid_o & !ready_i.

Test Plan:
- Basic sum (defaults): reset, beats (1,2),(3,4),(5,6),(7,8) back-to-back → valid_o the cycle after the 4th accept, sum_o=36 (0x24), overflow_o=0.
- Backpressure: hold ready_i=0 for 3 cycles in DONE → valid_o=1, sum_o=36 stable, ready_o=0 throughout. Then ready_i=1 → next cycle valid_o=0, ready_o=1, sum_o=0.
- Max operands: 4 beats of a=b=15 → sum_o=120, overflow_o=0. With sum_width_p=6 → sum_o=56, overflow_o=1, which clears to 0 after the handshake.
- Bubbles: valid_i toggled 1,0,0,1,0,1,1 with beats (1,1),(2,2),(3,3),(4,4) on the valid cycles → exactly one result, sum_o=20, after the 4th valid beat only.
- Reset mid-operation: accept 2 beats of (15,15), assert reset_i one cycle, then beats (1,0)x4 → sum_o=4; no result emitted for the aborted transaction.
- beats_p=1: beat (9,6) → valid_o next cycle with sum_o=15. Hold valid_i with (2,3) during DONE → that beat is not accepted until after the handshake, then yields sum_o=5.
